// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS32 control unit: opcode values,
// FSM state and instruction-class enums, datapath mux encodings, the fault
// code and the bundle of control outputs produced by the output decoder.
package mips_ctrl_pkg;

   // IR[31:26] values recognised by the decoder
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpShift = 6'b110000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;

   typedef enum logic [1:0] {
      AluAdd   = 2'b00,
      AluSub   = 2'b01,
      AluFunct = 2'b10,
      AluAnd   = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SrcBRt    = 2'b00,
      SrcBFour  = 2'b01,
      SrcBImm   = 2'b10,
      SrcBImmSh = 2'b11
   } src_b_e;

   typedef enum logic [1:0] {
      PcSrcAlu    = 2'b00,
      PcSrcAluOut = 2'b01,
      PcSrcJump   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      FaultNone    = 2'b00,
      FaultIllegal = 2'b01,
      FaultTimeout = 2'b10
   } fault_e;

   // Instruction class latched in DECODE; ClsNone is the reset value
   typedef enum logic [3:0] {
      ClsNone,
      ClsR,
      ClsSh,
      ClsAddi,
      ClsAndi,
      ClsLw,
      ClsSw,
      ClsBeq,
      ClsJ,
      ClsIllegal
   } cls_e;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAddr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecSh,
      StExecI,
      StAluWb,
      StBranch,
      StJump,
      StTrap
   } state_e;

   typedef struct packed {
      logic    mem_req;
      logic    mem_we;
      logic    i_or_d;
      logic    ir_write;
      logic    pc_write;
      logic    pc_write_cond;
      pc_src_e pc_source;
      logic    alu_src_a;
      src_b_e  alu_src_b;
      alu_op_e alu_op;
      logic    reg_dst;
      logic    mem_to_reg;
      logic    reg_write;
      logic    retire;
   } ctrl_t;

   function automatic cls_e decode_class(input logic [5:0] op);
      cls_e cls;
      case (op)
         OpRtype: cls = ClsR;
         OpShift: cls = ClsSh;
         OpAddi:  cls = ClsAddi;
         OpAndi:  cls = ClsAndi;
         OpLw:    cls = ClsLw;
         OpSw:    cls = ClsSw;
         OpBeq:   cls = ClsBeq;
         OpJ:     cls = ClsJ;
         default: cls = ClsIllegal;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter. Counts cycles a request spends waiting for mem_ready
// and flags the cycle in which the wait budget is used up.
//   clk, reset_n : clock, async active-low reset
//   clear_i      : zero the counter (on entry to a wait state)
//   count_i      : a wait cycle is being spent (request pending, not ready)
//   timeout_o    : this wait cycle is the MEM_TIMEOUT-th one; never set when
//                  MEM_TIMEOUT is 0
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TMR_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic count_i,
   output logic timeout_o
);

   // With the timeout disabled the counter simply saturates at all-ones
   localparam int unsigned SatInt  = (MEM_TIMEOUT == 0) ? ((1 << TMR_W) - 1) : MEM_TIMEOUT;
   localparam int unsigned LastInt = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
   localparam logic [TMR_W-1:0] SatVal  = TMR_W'(SatInt);
   localparam logic [TMR_W-1:0] LastVal = TMR_W'(LastInt);
   localparam logic Enabled = (MEM_TIMEOUT != 0);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i && (cnt_q != SatVal)) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the wait cycles already spent, so this is the last allowed one
   assign timeout_o = Enabled && count_i && (cnt_q == LastVal);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS32 control unit. Sequences each instruction through
// fetch / decode / execute / memory / write-back and drives the shared
// ALU and memory datapath controls.
//   clk, reset_n       : clock, async active-low reset (outputs forced 0)
//   opcode             : IR[31:26], sampled in DECODE
//   mem_ready          : memory completes the pending request this cycle
//   mem_req, mem_we    : memory request / write qualifier
//   i_or_d             : address select (0 PC, 1 ALUOut)
//   ir_write, pc_write, pc_write_cond, pc_source : IR / PC update controls
//   alu_src_a, alu_src_b, alu_op                 : ALU operand and op select
//   reg_dst, mem_to_reg, reg_write               : register file controls
//   retire             : one-cycle pulse when an instruction completes
//   fault              : sticky 00 none, 01 illegal opcode, 10 memory timeout
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TMR_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1,
   parameter int unsigned ALU_OP_W    = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [5:0]          opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [1:0]          pc_source,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                retire,
   output logic [1:0]          fault
);

   import mips_ctrl_pkg::*;

   state_e state_q, state_d;
   cls_e   cls_q, cls_d;
   fault_e fault_q, fault_d;
   cls_e   dec_cls;
   ctrl_t  ctrl;

   logic wait_q, wait_d;
   logic tmr_clear, tmr_count, tmr_timeout;

   assign dec_cls = decode_class(opcode);

   // States in which a memory request is outstanding
   assign wait_q = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
   assign wait_d = (state_d == StFetch) || (state_d == StMemRead) || (state_d == StMemWrite);

   assign tmr_clear = wait_d && (state_d != state_q);
   assign tmr_count = wait_q && !mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (tmr_clear),
      .count_i   (tmr_count),
      .timeout_o (tmr_timeout)
   );

   // State, class and fault registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         cls_q   <= ClsNone;
         fault_q <= FaultNone;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         fault_q <= fault_d;
      end
   end

   // Next state; in wait states mem_ready takes priority over timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: begin
            if (mem_ready)        state_d = StDecode;
            else if (tmr_timeout) state_d = StTrap;
         end
         StDecode: begin
            unique case (dec_cls)
               ClsR:          state_d = StExecR;
               ClsSh:         state_d = StExecSh;
               ClsAddi,
               ClsAndi:       state_d = StExecI;
               ClsLw,
               ClsSw:         state_d = StMemAddr;
               ClsBeq:        state_d = StBranch;
               ClsJ:          state_d = StJump;
               default:       state_d = StTrap;
            endcase
         end
         StMemAddr:  state_d = (cls_q == ClsLw) ? StMemRead : StMemWrite;
         StMemRead: begin
            if (mem_ready)        state_d = StMemWb;
            else if (tmr_timeout) state_d = StTrap;
         end
         StMemWb:    state_d = StFetch;
         StMemWrite: begin
            if (mem_ready)        state_d = StFetch;
            else if (tmr_timeout) state_d = StTrap;
         end
         StExecR,
         StExecSh,
         StExecI:    state_d = StAluWb;
         StAluWb,
         StBranch,
         StJump:     state_d = StFetch;
         StTrap:     state_d = StTrap;
         default:    state_d = StFetch;
      endcase
   end

   always_comb begin
      cls_d = (state_q == StDecode) ? dec_cls : cls_q;
   end

   // First fault wins and is held until reset
   always_comb begin
      fault_d = fault_q;
      if (fault_q == FaultNone) begin
         if ((state_q == StDecode) && (dec_cls == ClsIllegal)) begin
            fault_d = FaultIllegal;
         end else if (tmr_timeout && wait_q && !mem_ready) begin
            fault_d = FaultTimeout;
         end
      end
   end

   // Output decode
   always_comb begin
      ctrl = '0;
      unique case (state_q)
         StFetch: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = SrcBFour;
            ctrl.alu_op    = AluAdd;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         StDecode: begin
            ctrl.alu_src_b = SrcBImmSh;
            ctrl.alu_op    = AluAdd;
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluAdd;
         end
         StMemRead: begin
            ctrl.mem_req = 1'b1;
            ctrl.i_or_d  = 1'b1;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.retire     = 1'b1;
         end
         StMemWrite: begin
            ctrl.mem_req = 1'b1;
            ctrl.mem_we  = 1'b1;
            ctrl.i_or_d  = 1'b1;
            ctrl.retire  = mem_ready;
         end
         StExecR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBRt;
            ctrl.alu_op    = AluFunct;
         end
         StExecSh: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluFunct;
         end
         StExecI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = (cls_q == ClsAndi) ? AluAnd : AluAdd;
         end
         StAluWb: begin
            ctrl.reg_write = 1'b1;
            ctrl.retire    = 1'b1;
            ctrl.reg_dst   = (cls_q == ClsR) || (cls_q == ClsSh);
         end
         StBranch: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SrcBRt;
            ctrl.alu_op        = AluSub;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PcSrcAluOut;
            ctrl.retire        = 1'b1;
         end
         StJump: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PcSrcJump;
            ctrl.retire    = 1'b1;
         end
         StTrap:  ;
         default: ;
      endcase
   end

   // Reset forces every output low, even though the state already reads FETCH
   assign mem_req       = reset_n & ctrl.mem_req;
   assign mem_we        = reset_n & ctrl.mem_we;
   assign i_or_d        = reset_n & ctrl.i_or_d;
   assign ir_write      = reset_n & ctrl.ir_write;
   assign pc_write      = reset_n & ctrl.pc_write;
   assign pc_write_cond = reset_n & ctrl.pc_write_cond;
   assign pc_source     = reset_n ? ctrl.pc_source : 2'b00;
   assign alu_src_a     = reset_n & ctrl.alu_src_a;
   assign alu_src_b     = reset_n ? ctrl.alu_src_b : 2'b00;
   assign alu_op        = reset_n ? ALU_OP_W'(ctrl.alu_op) : '0;
   assign reg_dst       = reset_n & ctrl.reg_dst;
   assign mem_to_reg    = reset_n & ctrl.mem_to_reg;
   assign reg_write     = reset_n & ctrl.reg_write;
   assign retire        = reset_n & ctrl.retire;
   assign fault         = reset_n ? fault_q : 2'b00;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SH   = 6'b110000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_dst, mem_to_reg, reg_write, retire;
   logic [1:0] fault;

   always #5 clk = ~clk;

   multicycle_control #(
      .MEM_TIMEOUT (4)
   ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .retire        (retire),
      .fault         (fault)
   );

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       retire;
      logic [1:0] fault;
   } out_t;

   typedef enum {
      XZero, XFetch, XFetchRdy, XDecode, XMemAddr, XMemRd, XMemWb, XMemWr, XMemWrRdy,
      XExecR, XExecSh, XAddi, XAndi, XWbRd, XWbRt, XBranch, XJump, XTrapIll, XTrapTo
   } xs_e;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       rdy;
      xs_e        x;
   } vec_t;

   out_t act;
   assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                 alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retire, fault};

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   // Expected outputs for each state, written out from the state table
   function automatic out_t ex(input xs_e s);
      out_t e = '0;
      case (s)
         XFetch:    begin e.mem_req = 1; e.alu_src_b = 2'b01; end
         XFetchRdy: begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1; end
         XDecode:   e.alu_src_b = 2'b11;
         XMemAddr:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         XMemRd:    begin e.mem_req = 1; e.i_or_d = 1; end
         XMemWb:    begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
         XMemWr:    begin e.mem_req = 1; e.mem_we = 1; e.i_or_d = 1; end
         XMemWrRdy: begin e.mem_req = 1; e.mem_we = 1; e.i_or_d = 1; e.retire = 1; end
         XExecR:    begin e.alu_src_a = 1; e.alu_src_b = 2'b00; e.alu_op = 2'b10; end
         XExecSh:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
         XAddi:     begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b00; end
         XAndi:     begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
         XWbRd:     begin e.reg_write = 1; e.retire = 1; e.reg_dst = 1; end
         XWbRt:     begin e.reg_write = 1; e.retire = 1; end
         XBranch:   begin
            e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
            e.pc_source = 2'b01; e.retire = 1;
         end
         XJump:     begin e.pc_write = 1; e.pc_source = 2'b10; e.retire = 1; end
         XTrapIll:  e.fault = 2'b01;
         XTrapTo:   e.fault = 2'b10;
         default:   e = '0;
      endcase
      return e;
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic rdy, input xs_e x);
      vec_t v;
      v.rst = r; v.op = op; v.rdy = rdy; v.x = x;
      vecs.push_back(v);
   endtask

   task automatic chk_out(input string name, input out_t got, input out_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Apply inputs on the falling edge and leave 1 ns for outputs to settle
   task automatic step(input logic r, input logic [5:0] op, input logic rdy);
      @(negedge clk);
      reset_n = r; opcode = op; mem_ready = rdy;
      #1;
   endtask

   initial begin
      int lat;
      reset_n = 1'b0; opcode = '0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);

      add(0, OP_ADD, 0, XZero);
      // add: 4 cycles, mem_ready held high everywhere
      add(1, OP_ADD, 1, XFetchRdy); add(1, OP_ADD, 1, XDecode);
      add(1, OP_ADD, 1, XExecR);    add(1, OP_ADD, 1, XWbRd);
      // lw with 3 wait cycles: 8 cycles
      add(1, OP_LW, 1, XFetchRdy);  add(1, OP_LW, 1, XDecode);  add(1, OP_LW, 0, XMemAddr);
      add(1, OP_LW, 0, XMemRd);     add(1, OP_LW, 0, XMemRd);   add(1, OP_LW, 0, XMemRd);
      add(1, OP_LW, 1, XMemRd);     add(1, OP_LW, 1, XMemWb);
      // beq, then a fetch that waits one cycle
      add(1, OP_BEQ, 1, XFetchRdy); add(1, OP_BEQ, 1, XDecode); add(1, OP_BEQ, 0, XBranch);
      add(1, OP_J, 0, XFetch);
      // j
      add(1, OP_J, 1, XFetchRdy);   add(1, OP_J, 1, XDecode);   add(1, OP_J, 1, XJump);
      // addi / andi / shift
      add(1, OP_ADDI, 1, XFetchRdy); add(1, OP_ADDI, 1, XDecode);
      add(1, OP_ADDI, 1, XAddi);     add(1, OP_ADDI, 1, XWbRt);
      add(1, OP_ANDI, 1, XFetchRdy); add(1, OP_ANDI, 1, XDecode);
      add(1, OP_ANDI, 1, XAndi);     add(1, OP_ANDI, 1, XWbRt);
      add(1, OP_SH, 1, XFetchRdy);   add(1, OP_SH, 1, XDecode);
      add(1, OP_SH, 1, XExecSh);     add(1, OP_SH, 1, XWbRd);
      // sw, ready on the 4th MEM_WRITE cycle: no fault, retire
      add(1, OP_SW, 1, XFetchRdy);  add(1, OP_SW, 1, XDecode);  add(1, OP_SW, 1, XMemAddr);
      add(1, OP_SW, 0, XMemWr);     add(1, OP_SW, 0, XMemWr);   add(1, OP_SW, 0, XMemWr);
      add(1, OP_SW, 1, XMemWrRdy);  add(1, OP_SW, 0, XFetch);
      // sw, ready never comes: trap with timeout after 4 wait cycles
      add(1, OP_SW, 1, XFetchRdy);  add(1, OP_SW, 1, XDecode);  add(1, OP_SW, 0, XMemAddr);
      add(1, OP_SW, 0, XMemWr);     add(1, OP_SW, 0, XMemWr);   add(1, OP_SW, 0, XMemWr);
      add(1, OP_SW, 0, XMemWr);     add(1, OP_SW, 0, XTrapTo);  add(1, OP_SW, 1, XTrapTo);
      add(0, OP_SW, 0, XZero);
      // fetch timeout
      add(1, OP_ADD, 0, XFetch);    add(1, OP_ADD, 0, XFetch);  add(1, OP_ADD, 0, XFetch);
      add(1, OP_ADD, 0, XFetch);    add(1, OP_ADD, 0, XTrapTo); add(0, OP_ADD, 0, XZero);
      // illegal opcode: trap, outputs stay low, reset restarts at FETCH
      add(1, OP_BAD, 1, XFetchRdy); add(1, OP_BAD, 1, XDecode); add(1, OP_BAD, 1, XTrapIll);
      add(1, OP_BAD, 0, XTrapIll);  add(1, OP_BAD, 1, XTrapIll);
      add(0, OP_BAD, 1, XZero);     add(1, OP_ADD, 0, XFetch);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].op, vecs[i].rdy);
         chk_out($sformatf("vec%0d", i), act, ex(vecs[i].x));
      end

      // Reset in the middle of a MEM_WRITE wait
      step(0, OP_SW, 0);
      step(1, OP_SW, 1); step(1, OP_SW, 1); step(1, OP_SW, 1);
      step(1, OP_SW, 0); step(1, OP_SW, 0);
      chk_int("pre_rst_req_we", int'({mem_req, mem_we}), 3);
      #2 reset_n = 1'b0;
      #1;
      chk_int("rst_req_we_drop", int'({mem_req, mem_we}), 0);
      chk_int("rst_cnt_clear", int'(u_dut.u_timer.cnt_q), 0);
      step(1, OP_ADD, 0);
      chk_out("rel_fetch", act, ex(XFetch));
      chk_int("rel_cnt", int'(u_dut.u_timer.cnt_q), 0);
      step(1, OP_ADD, 0); step(1, OP_ADD, 0);
      step(1, OP_ADD, 1);
      chk_out("rel_fetch_rdy4", act, ex(XFetchRdy));
      step(1, OP_ADD, 1);
      chk_out("rel_decode", act, ex(XDecode));

      // lw latency with 2 wait cycles, bounded by a cycle budget
      step(0, OP_LW, 1);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         step(1, OP_LW, (c == 4 || c == 5) ? 1'b0 : 1'b1);
         if (retire) lat = c;
      end
      chk_int("lw_latency_k2", lat, 7);
      step(1, OP_LW, 1);
      chk_int("lw_retire_pulse", int'({retire, mem_req}), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
